// File: rtl/cam_capture.sv
// cam_capture: camera capture stage running on the system clock.
// Oversamples the camera pins, pairs bytes into RGB565 pixels tagged with
// x/y, buffers them in a small first-word fall-through FIFO and presents
// them on a valid/ready stream. Each debounced shutter press captures one
// frame.
// Optional build macro: CAM_TEST_PATTERN_EN replaces the pixel value with
// eight vertical colour bars. Timing and coordinates are unchanged.
module cam_capture #(
    parameter  int H_ACTIVE        = 640,
    parameter  int V_ACTIVE        = 480,
    parameter  int FIFO_DEPTH      = 16,
    parameter  int DEBOUNCE_CYCLES = 500000,
    localparam int XW              = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int YW              = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cam_pclk,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    input  logic          shutter_sw,
    output logic [15:0]   pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_sof,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          frame_done,
    output logic          overflow,
    output logic          busy
);

    // Internal coordinate counters are one value wider than the outputs so
    // they can sit at H_ACTIVE / V_ACTIVE (the "outside" value) without wrapping.
    localparam int XCW = $clog2(H_ACTIVE + 1);
    localparam int YCW = $clog2(V_ACTIVE + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [XCW-1:0] X_MAX    = XCW'(H_ACTIVE);
    localparam logic [YCW-1:0] Y_MAX    = YCW'(V_ACTIVE);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [15:0]   data;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
    } entry_t;

    // Camera synchronizers and pclk edge history
    logic       r_pclk_s1, r_pclk_s2, r_pclk_prev;
    logic       r_vs_s1, r_vs_s2;
    logic       r_hr_s1, r_hr_s2;
    logic [7:0] r_dat_s1, r_dat_s2;
    logic       r_vs_last, r_hr_last;
    logic       w_rise;

    // Shutter path
    logic           r_sh_s1, r_sh_s2, r_sh_db, r_db_prev;
    logic [DCW-1:0] r_db_cnt;
    logic           w_arm;

    // FSM and capture datapath
    state_t         r_state, w_next;
    logic [XCW-1:0] r_x;
    logic [YCW-1:0] r_y;
    logic           r_phase;
    logic [7:0]     r_hi;
    logic           w_sof_edge;
    logic           w_push;
    logic [15:0]    w_pix;
    entry_t         w_wr_entry;

    // FIFO
    entry_t      r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] r_count;
    logic        w_empty, w_full, w_pop, w_wr_en;
    entry_t      w_head;
    logic        r_ovf;

    // Two-flop synchronizers on every camera pin plus previous synced pclk.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source, which is what makes the chain a chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pclk_s1   <= 1'b0;
            r_pclk_s2   <= 1'b0;
            r_pclk_prev <= 1'b0;
            r_vs_s1     <= 1'b0;
            r_vs_s2     <= 1'b0;
            r_hr_s1     <= 1'b0;
            r_hr_s2     <= 1'b0;
            r_dat_s1    <= '0;
            r_dat_s2    <= '0;
        end else begin
            r_pclk_s1   <= cam_pclk;
            r_pclk_s2   <= r_pclk_s1;
            r_pclk_prev <= r_pclk_s2;
            r_vs_s1     <= cam_vsync;
            r_vs_s2     <= r_vs_s1;
            r_hr_s1     <= cam_href;
            r_hr_s2     <= r_hr_s1;
            r_dat_s1    <= cam_data;
            r_dat_s2    <= r_dat_s1;
        end
    end

    assign w_rise = r_pclk_s2 & ~r_pclk_prev;

    // Remember vsync/href as sampled on the previous pclk rise for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_last <= 1'b0;
            r_hr_last <= 1'b0;
        end else if (w_rise) begin
            r_vs_last <= r_vs_s2;
            r_hr_last <= r_hr_s2;
        end
    end

    // Shutter sync and debounce: level follows input only after a stable run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_s1   <= 1'b0;
            r_sh_s2   <= 1'b0;
            r_sh_db   <= 1'b0;
            r_db_prev <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_sh_s1   <= shutter_sw;
            r_sh_s2   <= r_sh_s1;
            r_db_prev <= r_sh_db;
            if (r_sh_s2 != r_sh_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_sh_db  <= r_sh_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_arm      = r_sh_db & ~r_db_prev;
    assign w_sof_edge = w_rise & ~r_vs_s2 & r_vs_last;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM next-state logic.
    // NOTE: w_next gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_arm)             w_next = S_WAIT_SOF;
            S_WAIT_SOF: if (w_sof_edge)        w_next = S_CAPTURE;
            S_CAPTURE:  if (w_rise && r_vs_s2) w_next = S_DRAIN;
            S_DRAIN:    if (w_empty)           w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy       = (r_state != S_IDLE);
        frame_done = (r_state == S_DRAIN) && w_empty;
    end

    // Byte pairing and x/y tracking; counters park at the active limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
            r_hi    <= '0;
        end else if (r_state == S_WAIT_SOF && w_sof_edge) begin
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
        end else if (r_state == S_CAPTURE && w_rise && !r_vs_s2) begin
            if (r_hr_s2) begin
                if (!r_phase) begin
                    r_hi    <= r_dat_s2;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (r_x < X_MAX) r_x <= r_x + 1'b1;
                end
            end else if (r_hr_last) begin
                // End of line: only a line that produced pixels advances y.
                if (r_x != '0 && r_y < Y_MAX) r_y <= r_y + 1'b1;
                r_x     <= '0;
                r_phase <= 1'b0;
            end
        end
    end

    assign w_push = (r_state == S_CAPTURE) && w_rise && !r_vs_s2 && r_hr_s2
                    && r_phase && (r_x < X_MAX) && (r_y < Y_MAX);

`ifdef CAM_TEST_PATTERN_EN
    function automatic logic [15:0] bar_colour(input logic [XCW-1:0] x);
        int idx;
        idx = (int'(x) * 8) / H_ACTIVE;
        case (idx)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    assign w_pix = bar_colour(r_x);
`else
    assign w_pix = {r_hi, r_dat_s2};
`endif

    assign w_wr_entry.data = w_pix;
    assign w_wr_entry.x    = r_x[XW-1:0];
    assign w_wr_entry.y    = r_y[YW-1:0];
    assign w_wr_entry.sof  = (r_x == '0) && (r_y == '0);

    // FIFO flags; a pop in the same cycle frees the slot for a push when full.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = !w_empty && pix_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage.
    // NOTE: the memory array is deliberately not reset; emptiness is tracked by
    // the pointers and the outputs are gated by pix_valid, so stale contents
    // are never visible.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_entry;
    end

    // Sticky overflow: set on a dropped pixel, cleared by the arm that starts a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_IDLE && w_arm) begin
            r_ovf <= 1'b0;
        end else if (w_push && !w_wr_en) begin
            r_ovf <= 1'b1;
        end
    end

    // Stream outputs from the head entry, forced to zero while empty.
    assign w_head    = r_mem[r_rd_ptr];
    assign pix_valid = !w_empty;
    assign pix_data  = pix_valid ? w_head.data : '0;
    assign pix_x     = pix_valid ? w_head.x    : '0;
    assign pix_y     = pix_valid ? w_head.y    : '0;
    assign pix_sof   = pix_valid && w_head.sof;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed bench for cam_capture with a 4x2 active area,
// 4-entry FIFO and 2000-cycle debounce. Camera pclk runs at clk/4.
module tb_cam_capture;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int DEPTH = 4;
    localparam int DEB   = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        shutter_sw = 1'b0;
    logic        pix_ready = 1'b1;
    logic [15:0] pix_data;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic        pix_sof, pix_valid, frame_done, overflow, busy;

    cam_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .shutter_sw(shutter_sw),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_done(frame_done), .overflow(overflow), .busy(busy)
    );

    always #10 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: records every accepted pixel, frame_done pulses and busy rises.
    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        s;
    } pix_t;

    pix_t q[$];
    int   fd_cnt = 0;
    int   busy_rise = 0;
    logic busy_d = 1'b0;

    always @(negedge clk) begin
        if (pix_valid && pix_ready)
            q.push_back('{d: pix_data, x: 8'(pix_x), y: 8'(pix_y), s: pix_sof});
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (busy && !busy_d) busy_rise <= busy_rise + 1;
        busy_d <= busy;
    end

    function automatic logic [15:0] exp_pix(input int x, input logic [15:0] cam);
        logic        use_bars;
        logic [15:0] bar;
`ifdef CAM_TEST_PATTERN_EN
        use_bars = 1'b1;
`else
        use_bars = 1'b0;
`endif
        case ((x * 8) / H)
            0:       bar = 16'hFFFF;
            1:       bar = 16'hFFE0;
            2:       bar = 16'h07FF;
            3:       bar = 16'h07E0;
            4:       bar = 16'hF81F;
            5:       bar = 16'hF800;
            6:       bar = 16'h001F;
            default: bar = 16'h0000;
        endcase
        return use_bars ? bar : cam;
    endfunction

    task automatic check_px(input int i, input logic [15:0] d, input int x, input int y,
                            input logic s);
        string t;
        t = $sformatf("px%0d", i);
        if (i < q.size()) begin
            check({t, "_data"}, q[i].d, exp_pix(x, d));
            check({t, "_x"},    q[i].x, x);
            check({t, "_y"},    q[i].y, y);
            check({t, "_sof"},  q[i].s, s);
        end else begin
            check({t, "_missing"}, q.size(), i + 1);
        end
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_valid"}, pix_valid, 0);
        check({p, "_data"},  pix_data, 0);
        check({p, "_x"},     pix_x, 0);
        check({p, "_y"},     pix_y, 0);
        check({p, "_sof"},   pix_sof, 0);
        check({p, "_fd"},    frame_done, 0);
        check({p, "_ovf"},   overflow, 0);
        check({p, "_busy"},  busy, 0);
    endtask

    // One camera pclk period (4 clk): inputs change while pclk is low.
    task automatic pclk_cycle(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge clk); #2;
        cam_pclk = 1'b0; cam_vsync = vs; cam_href = hr; cam_data = d;
        @(posedge clk); #2;
        @(posedge clk); #2;
        cam_pclk = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic vsync_start();
        repeat (2) pclk_cycle(1'b1, 1'b0, 8'h00);
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vsync_end();
        repeat (2) pclk_cycle(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_line(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) pclk_cycle(1'b0, 1'b1, base + 8'(i));
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string tag);
        @(negedge clk);
        for (int i = 0; i < max; i++) begin
            if (busy === lvl) break;
            @(negedge clk);
        end
        check(tag, busy, lvl);
    endtask

    task automatic arm_shutter(input string tag);
        @(posedge clk); #2;
        shutter_sw = 1'b0;
        repeat (DEB + 50) @(posedge clk);
        #2;
        shutter_sw = 1'b1;
        wait_busy(1'b1, DEB + 100, tag);
    endtask

    // Byte pair for pixel k of a line starting at byte 'base'.
    function automatic logic [15:0] pair(input logic [7:0] base, input int k);
        logic [7:0] hi;
        hi = base + 8'(2 * k);
        return {hi, hi + 8'd1};
    endfunction

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #2;
        reset = 1'b0;

        // Shutter bounce: 20 toggles of 1000 cycles, then hold high
        for (int t = 0; t < 20; t++) begin
            repeat (1000) @(posedge clk);
            #2;
            shutter_sw = ~shutter_sw;
        end
        check("bounce_no_arm", busy_rise, 0);
        shutter_sw = 1'b1;
        wait_busy(1'b1, DEB + 100, "bounce_armed");
        repeat (50) @(negedge clk);
        check("bounce_one_arm", busy_rise, 1);

        // Basic 4x2 frame with pix_ready held high
        q.delete();
        fd0 = fd_cnt;
        vsync_start();
        send_line(8'h10, 8);
        send_line(8'h20, 8);
        vsync_end();
        wait_busy(1'b0, 200, "basic_done");
        check("basic_count", q.size(), 8);
        for (int i = 0; i < 8; i++)
            check_px(i, pair((i < 4) ? 8'h10 : 8'h20, i % 4), i % 4, i / 4, i == 0);
        check("basic_fd", fd_cnt - fd0, 1);

        // Backpressure: nothing popped during the frame, FIFO keeps the first 4
        arm_shutter("bp_arm");
        @(posedge clk); #2;
        pix_ready = 1'b0;
        q.delete();
        fd0 = fd_cnt;
        vsync_start();
        send_line(8'h10, 8);
        send_line(8'h20, 8);
        vsync_end();
        repeat (20) @(negedge clk);
        check("bp_overflow", overflow, 1);
        check("bp_busy_drain", busy, 1);
        check("bp_valid", pix_valid, 1);
        check("bp_head", pix_data, exp_pix(0, 16'h1011));
        check("bp_no_fd", fd_cnt - fd0, 0);
        @(posedge clk); #2;
        pix_ready = 1'b1;
        wait_busy(1'b0, 100, "bp_done");
        check("bp_count", q.size(), 4);
        for (int i = 0; i < 4; i++) check_px(i, pair(8'h10, i), i, 0, i == 0);
        check("bp_fd", fd_cnt - fd0, 1);
        check("bp_ovf_sticky", overflow, 1);

        // Odd/long line, then a line past V_ACTIVE
        arm_shutter("odd_arm");
        check("odd_ovf_cleared", overflow, 0);
        q.delete();
        vsync_start();
        send_line(8'h30, 11);
        send_line(8'h40, 4);
        send_line(8'h50, 4);
        vsync_end();
        wait_busy(1'b0, 200, "odd_done");
        check("odd_count", q.size(), 6);
        for (int i = 0; i < 4; i++) check_px(i, pair(8'h30, i), i, 0, i == 0);
        check_px(4, 16'h4041, 0, 1, 1'b0);
        check_px(5, 16'h4243, 1, 1, 1'b0);

        // Reset mid-frame after 3 pixels
        arm_shutter("rst_arm");
        @(posedge clk); #2;
        pix_ready = 1'b0;
        q.delete();
        vsync_start();
        for (int i = 0; i < 6; i++) pclk_cycle(1'b0, 1'b1, 8'h70 + 8'(i));
        repeat (10) @(negedge clk);
        check("rst_pre_valid", pix_valid, 1);
        @(posedge clk); #2;
        reset = 1'b1;
        cam_href = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        @(posedge clk); #2;
        pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        // A full frame before any arm must produce nothing
        vsync_start();
        send_line(8'h80, 4);
        vsync_end();
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
        repeat (10) @(negedge clk);
        check("rst_no_pix_unarmed", q.size(), 0);
        check("rst_idle", busy, 0);
        // Shutter is still held, so the debouncer re-arms after reset
        wait_busy(1'b1, DEB + 100, "rst_rearm");
        send_line(8'h90, 4);
        repeat (10) @(negedge clk);
        check("rst_no_pix_no_sof", q.size(), 0);
        check("rst_wait_sof_busy", busy, 1);
        vsync_start();
        send_line(8'hA0, 4);
        vsync_end();
        wait_busy(1'b0, 200, "rst_frame_done");
        check("rst_count", q.size(), 2);
        check_px(0, 16'hA0A1, 0, 0, 1'b1);
        check_px(1, 16'hA2A3, 1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
